// File: rtl/tristate_rx_pkg.sv
// Shared types and constants for the single-wire half-duplex receiver.
// Imported by the interface, the top level and the testbench.
package tristate_rx_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        GUARD,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/tristate_rx_if.sv
// Byte hand-off channel from the receiver to the consuming fabric logic.
// The receiver owns data/valid and the consumer owns ready.
interface tristate_rx_if;
    import tristate_rx_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pad input.
// Both stages reset to 1 so a pulled-up idle line never looks like a start bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/tristate_rx.sv
// Receive side of the half-duplex single-wire link: guards the bus turnaround,
// deframes start/8 data/stop bits and hands bytes out over valid/ready.
module tristate_rx
    import tristate_rx_pkg::*;
#(
    parameter int BIT_CLKS   = 16,
    parameter int GUARD_CLKS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          line_in,
    input  logic          oe,
    tristate_rx_if.master rx,
    output logic          frame_err,
    output logic          overrun,
    output logic          busy
);

    localparam int CNT_MAX = (BIT_CLKS > GUARD_CLKS + 1) ? BIT_CLKS : GUARD_CLKS + 1;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_CLKS);
    localparam logic [CNT_W-1:0] HALF_LD   = CNT_W'(BIT_CLKS / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LD    = CNT_W'(BIT_CLKS - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_W - 1);

    logic line_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (line_in),
        .q     (line_s)
    );

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;
    logic              deliver;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        if (valid_q && rx.rx_ready) begin
            valid_d = 1'b0;
        end

        // Our own driver owning the wire trumps everything: drop any partial frame.
        if (oe) begin
            state_d   = GUARD;
            cnt_d     = GUARD_LD;
            bit_idx_d = 3'd0;
        end else begin
            case (state_q)
                GUARD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (line_s) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (!line_s) begin
                        state_d = START;
                        cnt_d   = HALF_LD;
                    end
                end
                START: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (!line_s) begin
                        state_d   = DATA;
                        cnt_d     = BIT_LD;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        shift_d   = {line_s, shift_q[DATA_W-1:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        cnt_d     = BIT_LD;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (line_s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // A break parks in GUARD until the line returns high.
                        frame_err_d = 1'b1;
                        state_d     = GUARD;
                        cnt_d       = '0;
                    end
                end
                default: begin
                    state_d = GUARD;
                    cnt_d   = GUARD_LD;
                end
            endcase
        end

        if (deliver) begin
            if (!valid_q || rx.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GUARD;
            cnt_q       <= GUARD_LD;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx.rx_data  = data_q;
    assign rx.rx_valid = valid_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tristate_rx.sv
// Directed bench for tristate_rx: a cycle-arithmetic reference model is compared
// against the DUT every cycle, plus literal checks on key events.
module tb_tristate_rx;
    import tristate_rx_pkg::*;

    localparam int BIT_CLKS   = 16;
    localparam int GUARD_CLKS = 4;
    localparam int HALF       = BIT_CLKS / 2;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic line_in = 1'b1;
    logic oe      = 1'b0;
    logic frame_err;
    logic overrun;
    logic busy;

    tristate_rx_if rx_if ();

    tristate_rx #(
        .BIT_CLKS   (BIT_CLKS),
        .GUARD_CLKS (GUARD_CLKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (line_in),
        .oe        (oe),
        .rx        (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the frame is described by absolute cycle offsets from the
    // start-detect cycle rather than by counters.
    int          cyc       = 0;
    logic        m_s1      = 1'b1;
    logic        m_s2      = 1'b1;
    bit          m_idle    = 1'b0;
    bit          m_active  = 1'b0;
    int          ready_cyc = GUARD_CLKS + 1;
    int          frame_t   = 0;
    logic [7:0]  m_shift   = 8'h00;
    logic [7:0]  exp_data  = 8'h00;
    logic        exp_valid = 1'b0;
    logic        exp_ferr  = 1'b0;
    logic        exp_ovr   = 1'b0;
    logic        exp_busy  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1      = 1'b1;
            m_s2      = 1'b1;
            m_idle    = 1'b0;
            m_active  = 1'b0;
            ready_cyc = cyc + 1 + GUARD_CLKS;
            exp_data  = 8'h00;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            exp_ovr   = 1'b0;
            exp_busy  = 1'b0;
        end else begin
            logic ls;
            logic got_byte;
            logic accept;
            int   off;
            int   k;
            cyc++;
            ls       = m_s2;
            m_s2     = m_s1;
            m_s1     = line_in;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            got_byte = 1'b0;
            if (oe) begin
                m_active  = 1'b0;
                m_idle    = 1'b0;
                ready_cyc = cyc + 1 + GUARD_CLKS;
            end else if (m_active) begin
                off = cyc - frame_t;
                if (off == HALF) begin
                    if (ls) begin
                        m_active = 1'b0;
                        m_idle   = 1'b1;
                    end
                end else if (off > HALF && ((off - HALF) % BIT_CLKS) == 0) begin
                    k = (off - HALF) / BIT_CLKS;
                    if (k <= 8) begin
                        m_shift[k-1] = ls;
                    end else begin
                        m_active = 1'b0;
                        if (ls) begin
                            m_idle   = 1'b1;
                            got_byte = 1'b1;
                        end else begin
                            exp_ferr  = 1'b1;
                            ready_cyc = cyc + 1;
                        end
                    end
                end
            end else if (m_idle) begin
                if (!ls) begin
                    m_idle   = 1'b0;
                    m_active = 1'b1;
                    frame_t  = cyc;
                end
            end else if (cyc >= ready_cyc && ls) begin
                m_idle = 1'b1;
            end
            accept = exp_valid && rx_if.rx_ready;
            if (got_byte && (!exp_valid || accept)) begin
                exp_data  = m_shift;
                exp_valid = 1'b1;
            end else begin
                if (got_byte) exp_ovr = 1'b1;
                if (accept) exp_valid = 1'b0;
            end
            exp_busy = m_active;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("rx_valid", 32'(rx_if.rx_valid), 32'(exp_valid));
            checkOutput("rx_data", 32'(rx_if.rx_data), 32'(exp_data));
            checkOutput("frame_err", 32'(frame_err), 32'(exp_ferr));
            checkOutput("overrun", 32'(overrun), 32'(exp_ovr));
            checkOutput("busy", 32'(busy), 32'(exp_busy));
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
    end

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame from a negedge; abort_after < 8 raises oe for one cycle
    // after that many data bits instead of finishing the frame.
    task automatic applyStimulus(input logic [7:0] value, input logic stop_bit, input int abort_after);
        line_in = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_after) begin
                oe      = 1'b1;
                line_in = 1'b1;
                @(negedge clk);
                oe = 1'b0;
                return;
            end
            line_in = value[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        line_in = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        line_in = 1'b1;
    endtask

    task automatic waitValid(input int max_cycles, output int n);
        n = 0;
        while (n < max_cycles) begin
            @(posedge clk);
            n++;
            #1;
            if (rx_if.rx_valid === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic acceptByte();
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic lowGlitch(input int n);
        line_in = 1'b0;
        repeat (n) @(negedge clk);
        line_in = 1'b1;
    endtask

    initial begin
        int lat;
        int ferr_base;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(rx_if.rx_valid), 32'd0);
        checkOutput("reset_data", 32'(rx_if.rx_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        idleCycles(10);

        $display("[TB] byte 0xA5 with latency check");
        fork
            applyStimulus(8'hA5, 1'b1, 8);
            waitValid(400, lat);
        join
        checkOutput("a5_latency", 32'(lat), 32'd155);
        checkOutput("a5_data", 32'(rx_if.rx_data), 32'hA5);
        checkOutput("a5_no_err", 32'(ferr_cnt + ovr_cnt), 32'd0);
        idleCycles(2);
        acceptByte();
        checkOutput("a5_cleared", 32'(rx_if.rx_valid), 32'd0);

        $display("[TB] overrun with 0x3C then 0x7E");
        idleCycles(4);
        applyStimulus(8'h3C, 1'b1, 8);
        idleCycles(4);
        applyStimulus(8'h7E, 1'b1, 8);
        idleCycles(2);
        checkOutput("ovr_count", 32'(ovr_cnt), 32'd1);
        checkOutput("ovr_data_kept", 32'(rx_if.rx_data), 32'h3C);
        checkOutput("ovr_valid_kept", 32'(rx_if.rx_valid), 32'd1);
        rx_if.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ovr_valid_drop", 32'(rx_if.rx_valid), 32'd0);
        @(negedge clk);
        rx_if.rx_ready = 1'b0;

        $display("[TB] framing error on 0x55 then 0x12");
        idleCycles(4);
        applyStimulus(8'h55, 1'b0, 8);
        idleCycles(2);
        checkOutput("ferr_count", 32'(ferr_cnt), 32'd1);
        checkOutput("ferr_no_valid", 32'(rx_if.rx_valid), 32'd0);
        idleCycles(4);
        applyStimulus(8'h12, 1'b1, 8);
        idleCycles(2);
        checkOutput("after_ferr_data", 32'(rx_if.rx_data), 32'h12);
        checkOutput("after_ferr_valid", 32'(rx_if.rx_valid), 32'd1);
        acceptByte();

        $display("[TB] short glitch on idle line");
        ferr_base = ferr_cnt;
        idleCycles(4);
        lowGlitch(3);
        idleCycles(30);
        checkOutput("glitch_no_valid", 32'(rx_if.rx_valid), 32'd0);
        checkOutput("glitch_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);
        checkOutput("glitch_idle", 32'(busy), 32'd0);

        $display("[TB] oe abort mid-byte then 0x81");
        applyStimulus(8'hF0, 1'b1, 4);
        lowGlitch(3);
        idleCycles(10);
        checkOutput("abort_no_valid", 32'(rx_if.rx_valid), 32'd0);
        checkOutput("abort_no_busy", 32'(busy), 32'd0);
        applyStimulus(8'h81, 1'b1, 8);
        idleCycles(2);
        checkOutput("abort_data", 32'(rx_if.rx_data), 32'h81);
        checkOutput("abort_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

        $display("[TB] reset mid-frame");
        idleCycles(4);
        fork
            applyStimulus(8'h99, 1'b1, 8);
            begin
                repeat (40) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                checkOutput("rst_valid", 32'(rx_if.rx_valid), 32'd0);
                checkOutput("rst_data", 32'(rx_if.rx_data), 32'd0);
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_ferr", 32'(frame_err), 32'd0);
                checkOutput("rst_ovr", 32'(overrun), 32'd0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idleCycles(20);
        acceptByte();

        $display("[TB] start held low across reset release");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        line_in = 1'b0;
        for (int i = 0; i < GUARD_CLKS + 4; i++) begin
            @(negedge clk);
            checkOutput("guard_busy", 32'(busy), 32'd0);
        end
        line_in = 1'b1;
        idleCycles(6);
        applyStimulus(8'h24, 1'b1, 8);
        idleCycles(2);
        checkOutput("final_data", 32'(rx_if.rx_data), 32'h24);
        checkOutput("final_valid", 32'(rx_if.rx_valid), 32'd1);
        acceptByte();
        idleCycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tristate_rx.md
# tristate_rx

Receive side of a half-duplex single-wire serial link whose transmit side is the team's tristate pad driver. It samples the shared line only while the local driver is released, after a bus-turnaround guard. It deframes start / 8 data / stop bits into bytes and hands each byte to fabric logic over a valid/ready handshake. It sits between the bidirectional pad's input path and the register/command logic that consumes read-back data.

## Interface
- BIT_CLKS, 16: clk cycles per bit; even, ≥4.
- GUARD_CLKS, 4: cycles the line is ignored after local `oe` deasserts; ≥1.
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- line_in  in  1  raw pad input, asynchronous to clk; floating line reads 1 via pull-up.
- oe  in  1  local tristate driver enable; line is ignored while high.
- rx_data  out  8  received byte, LSB first on the wire; stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: new byte dropped because the previous byte was not accepted.
- busy  out  1  high in START, DATA, STOP.

## Operation
- line_in passes through a 2-flop synchronizer (both flops reset to 1). Its output is line_s. FSM and sampling use line_s only.
- States: GUARD, IDLE, START, DATA, STOP. One down-counter `cnt` (width clog2(max(BIT_CLKS,GUARD_CLKS+1))) and a 3-bit bit index.
- oe=1 in any state: next state GUARD, cnt←GUARD_CLKS, bit index←0. Any partial frame is discarded silently, with no error pulse. This has priority over every other transition.
- GUARD: decrement cnt while oe=0 until 0. At cnt=0 and line_s=1 → IDLE. At cnt=0 and line_s=0, stay (wait for idle-high).
- IDLE: line_s=0 → START, cnt←BIT_CLKS/2−1.
- START: decrement; at cnt=0 sample line_s. If 0 → DATA, cnt←BIT_CLKS−1. If 1 (glitch) → IDLE, no error.
- DATA: decrement; at cnt=0 shift line_s into shift-register MSB (shift right) and increment the bit index. After the 8th sample → STOP, cnt←BIT_CLKS−1.
- STOP: decrement; at cnt=0 sample line_s.
  - If 1: deliver the byte and go to IDLE.
  - If 0: frame_err pulse, byte discarded, go to GUARD with cnt=0. This waits for line high, so a break is never re-parsed as a start.
- Delivery:
  - If rx_valid=0, or rx_valid & rx_ready in the same cycle, load rx_data and set rx_valid.
  - Otherwise pulse overrun, keep the old rx_data/rx_valid, and drop the new byte.
- rx_valid clears on the cycle after rx_valid & rx_ready, unless a new byte loads in that same cycle.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0. The FSM resets to GUARD with cnt=GUARD_CLKS.
- Let t be the cycle IDLE sees line_s=0. line_s lags the pad by 2 cycles.
  - Start sampled at t+BIT_CLKS/2.
  - Data bit i sampled at t+BIT_CLKS/2+(i+1)·BIT_CLKS.
  - Stop bit sampled at t+BIT_CLKS/2+9·BIT_CLKS.
- rx_valid, frame_err and overrun are registered and assert 1 cycle after the stop sample. With BIT_CLKS=16 that is t+153.
- After oe falls, the earliest start detection is GUARD_CLKS+1 cycles later.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package tristate_rx_pkg holds the state enum (GUARD, IDLE, START, DATA, STOP) and the data-width constant (8).
- One sub-module, sync_2ff: a parameter-free 2-flop synchronizer with reset value 1, also reusable for other pad inputs.
- Everything else (FSM, counter, shift register, output holding register) lives in tristate_rx.

## Test plan
- Reset, BIT_CLKS=16, GUARD_CLKS=4, oe=0, line high; send 0xA5 → rx_valid at t+153 with rx_data=0xA5, no error pulses.
- Hold rx_ready=0; send 0x3C then 0x7E → second stop cycle gives overrun pulse, rx_data stays 0x3C. Raise rx_ready → rx_valid drops next cycle.
- Send 0x55 with the stop bit held low → frame_err pulse, rx_valid stays 0. Line must return high before 0x12 is then received correctly.
- 3-cycle low glitch on an idle line → START rejects it, FSM returns to IDLE, no rx_valid, no frame_err.
- Assert oe for 1 cycle mid-byte (after bit 3), then send 0x81 → partial frame dropped silently, 0x81 received. A start within 4 cycles of oe falling is ignored.
- Assert rst_n low mid-frame → all outputs 0 immediately. After release, the first start is not accepted before GUARD_CLKS+1 cycles.
